// File: rtl/processor_if.sv
// processor_if: word-indexed data-memory bus between the pipeline's MEM stage and its data memory.
interface processor_if;
    logic        we;
    logic [7:0]  idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output we, idx, wdata, input rdata);
    modport slave  (input we, idx, wdata, output rdata);
endinterface

// File: rtl/processor.sv
// processor: 5-stage in-order MIPS-subset core (add/sub/and/or/slt/addi/lw/sw) with internal memories,
// full EX/MEM and MEM/WB forwarding and a one-cycle load-use stall.
module flop #(parameter int W = 32) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] out
);
    always_ff @(posedge clk)
        if (reset) out <= '0;
        else if (en) out <= d;
endmodule

module imem #(parameter int WORDS = 256) (
    input  logic [7:0]  idx,
    output logic [31:0] data
);
    logic [31:0] block [0:WORDS-1];
    assign data = block[idx];
endmodule

module dmem #(parameter int WORDS = 256) (
    input logic        clk,
    processor_if.slave bus
);
    logic [31:0] block [0:WORDS-1];
    always_ff @(posedge clk)
        if (bus.we) block[bus.idx] <= bus.wdata;
    assign bus.rdata = block[bus.idx];
endmodule

module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] q [32];
    assign q[0] = '0;
    for (genvar i = 1; i < 32; i++) begin : rf_gen
        flop #(32) register (.clk, .reset, .en(we && wa == 5'(i)), .d(wd), .out(q[i]));
    end
    // write-through so an operand read in the same cycle as its WB sees the new value
    assign rd1 = (we && wa != 5'd0 && wa == ra1) ? wd : q[ra1];
    assign rd2 = (we && wa != 5'd0 && wa == ra2) ? wd : q[ra2];
endmodule

module fetch #(parameter int IMEM_WORDS = 256) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] instr
);
    flop #(32) program_counter (.clk, .reset, .en(!stall), .d(pc + 32'd4), .out(pc));
    imem #(.WORDS(IMEM_WORDS)) instr_memory (.idx(pc[9:2]), .data(instr));
endmodule

module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        use_imm,
    output logic [2:0]  alu_op,
    output logic [4:0]  dst
);
    logic [5:0] op, fn;
    logic       r_type, addi;
    logic       unused_shamt;
    regfile rf_main (.clk, .reset, .we(wb_we), .wa(wb_rd), .wd(wb_data),
                     .ra1(instr[25:21]), .ra2(instr[20:16]), .rd1, .rd2);
    assign unused_shamt = ^instr[10:6];
    always_comb begin
        op = instr[31:26];
        fn = instr[5:0];
        r_type = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a);
        addi = op == 6'h08;
        mem_read = op == 6'h23;
        mem_write = op == 6'h2b;
        reg_write = r_type || addi || mem_read;
        use_imm = addi || mem_read || mem_write;
        dst = r_type ? instr[15:11] : instr[20:16];
        imm = {{16{instr[15]}}, instr[15:0]};
        alu_op = !r_type ? 3'd0 : fn == 6'h22 ? 3'd1 : fn == 6'h24 ? 3'd2 :
                 fn == 6'h25 ? 3'd3 : fn == 6'h2a ? 3'd4 : 3'd0;
    end
endmodule

module mem_stage #(parameter int DMEM_WORDS = 256) (
    input logic        clk,
    processor_if.slave bus
);
    dmem #(.WORDS(DMEM_WORDS)) data_memory (.clk, .bus(bus));
endmodule

module processor #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic reset
);
    typedef struct packed {
        logic        reg_write, mem_read, mem_write, use_imm;
        logic [2:0]  alu_op;
        logic [4:0]  rs, rt, dst;
        logic [31:0] a, b, imm;
    } idex_t;
    typedef struct packed {
        logic        reg_write, mem_read, mem_write;
        logic [4:0]  dst;
        logic [31:0] alu, sdata;
    } exmem_t;
    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dst;
        logic [31:0] res;
    } memwb_t;

    logic        stall;
    logic [31:0] pc, if_instr, ifid_d, ifid_q;
    idex_t       idex_d, idex_q;
    exmem_t      exmem_d, exmem_q;
    memwb_t      memwb_d, memwb_q;
    logic [31:0] id_a, id_b, id_imm, fwd_a, fwd_b, op_b;
    logic        id_rw, id_mr, id_mw, id_ui;
    logic [2:0]  id_op;
    logic [4:0]  id_dst;
    processor_if dbus ();

    fetch #(.IMEM_WORDS(IMEM_WORDS)) if_main (.clk, .reset, .stall, .pc, .instr(if_instr));
    decode id_main (.clk, .reset, .instr(ifid_q), .wb_we(memwb_q.reg_write), .wb_rd(memwb_q.dst),
                    .wb_data(memwb_q.res), .rd1(id_a), .rd2(id_b), .imm(id_imm), .reg_write(id_rw),
                    .mem_read(id_mr), .mem_write(id_mw), .use_imm(id_ui), .alu_op(id_op), .dst(id_dst));
    mem_stage #(.DMEM_WORDS(DMEM_WORDS)) mem_main (.clk, .bus(dbus));

    assign dbus.we    = exmem_q.mem_write;
    assign dbus.idx   = exmem_q.alu[9:2];
    assign dbus.wdata = exmem_q.sdata;

    always_ff @(posedge clk)
        if (reset) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end

    always_comb begin
        stall = idex_q.mem_read && (idex_q.dst == ifid_q[25:21] || idex_q.dst == ifid_q[20:16]);
        ifid_d = stall ? ifid_q : if_instr;
        idex_d = '0;
        if (!stall) begin
            idex_d.reg_write = id_rw;
            idex_d.mem_read  = id_mr;
            idex_d.mem_write = id_mw;
            idex_d.use_imm   = id_ui;
            idex_d.alu_op    = id_op;
            idex_d.rs        = ifid_q[25:21];
            idex_d.rt        = ifid_q[20:16];
            idex_d.dst       = id_dst;
            idex_d.a         = id_a;
            idex_d.b         = id_b;
            idex_d.imm       = id_imm;
        end
        // the younger producer (EX/MEM) wins over MEM/WB
        fwd_a = (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rs) ? exmem_q.alu :
                (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rs) ? memwb_q.res : idex_q.a;
        fwd_b = (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rt) ? exmem_q.alu :
                (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rt) ? memwb_q.res : idex_q.b;
        op_b = idex_q.use_imm ? idex_q.imm : fwd_b;
        exmem_d.reg_write = idex_q.reg_write;
        exmem_d.mem_read  = idex_q.mem_read;
        exmem_d.mem_write = idex_q.mem_write;
        exmem_d.dst       = idex_q.dst;
        exmem_d.sdata     = fwd_b;
        exmem_d.alu = idex_q.alu_op == 3'd1 ? fwd_a - op_b :
                      idex_q.alu_op == 3'd2 ? fwd_a & op_b :
                      idex_q.alu_op == 3'd3 ? fwd_a | op_b :
                      idex_q.alu_op == 3'd4 ? {31'b0, $signed(fwd_a) < $signed(op_b)} : fwd_a + op_b;
        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.dst       = exmem_q.dst;
        memwb_d.res       = exmem_q.mem_read ? dbus.rdata : exmem_q.alu;
    end
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed program run with per-edge probes of PC, register file and data memory.
module tb_processor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] regs [1:31];

    processor dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    for (genvar g = 1; g < 32; g++) begin : probe
        assign regs[g] = dut.id_main.rf_main.rf_gen[g].register.out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic go(input int k);
        tick(k - cyc);
    endtask

    function automatic logic [31:0] enc_r(input int s, input int t, input int d, input int f);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, 6'(f)};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int s, input int t, input logic [15:0] im);
        return {op, 5'(s), 5'(t), im};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            dut.if_main.instr_memory.block[i] = 32'h0;
            dut.mem_main.data_memory.block[i] <= 32'h0;
        end
        dut.if_main.instr_memory.block[19] = enc_i(6'h08, 0, 1, 16'h0007);
        dut.if_main.instr_memory.block[20] = enc_i(6'h08, 0, 2, 16'h0100);
        dut.if_main.instr_memory.block[21] = enc_r(2, 2, 3, 'h20);
        dut.if_main.instr_memory.block[22] = enc_i(6'h08, 0, 4, 16'h0010);
        dut.if_main.instr_memory.block[23] = enc_i(6'h2b, 0, 2, 16'd12);
        dut.if_main.instr_memory.block[24] = enc_i(6'h2b, 0, 3, 16'd16);
        dut.if_main.instr_memory.block[25] = enc_i(6'h23, 0, 5, 16'd12);
        dut.if_main.instr_memory.block[26] = enc_r(5, 5, 6, 'h20);
        dut.if_main.instr_memory.block[27] = enc_r(0, 1, 6, 'h2a);
        dut.if_main.instr_memory.block[28] = enc_r(1, 1, 1, 'h22);
        dut.if_main.instr_memory.block[29] = enc_i(6'h08, 0, 0, 16'h0005);
        dut.if_main.instr_memory.block[30] = enc_r(0, 0, 7, 'h20);
        dut.if_main.instr_memory.block[31] = enc_i(6'h08, 0, 8, 16'h0001);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        chk("pc_reset", dut.if_main.program_counter.out, 32'h0);
        for (int k = 1; k <= 19; k++) begin
            tick(1);
            chk($sformatf("pc@%0d", k), dut.if_main.program_counter.out, 32'(4 * k));
        end
        for (int r = 1; r < 32; r++) chk($sformatf("nop_r%0d", r), regs[r], 32'h0);

        go(24); chk("addi_r1", regs[1], 32'h7);
        go(25); chk("addi_r2", regs[2], 32'h100);
        go(26); chk("fwd_add_r3", regs[3], 32'h200);
        go(27);
        chk("addi_r4", regs[4], 32'h10);
        chk("sw_m3", dut.mem_main.data_memory.block[3], 32'h100);
        chk("pc@27", dut.if_main.program_counter.out, 32'd108);
        go(28);
        chk("sw_m4", dut.mem_main.data_memory.block[4], 32'h200);
        chk("sw_not_m16", dut.mem_main.data_memory.block[16], 32'h0);
        chk("pc_stall@28", dut.if_main.program_counter.out, 32'd108);
        go(29); chk("pc@29", dut.if_main.program_counter.out, 32'd112);
        go(30); chk("lw_r5", regs[5], 32'h100);
        go(32); chk("loaduse_r6", regs[6], 32'h200);
        go(33); chk("slt_r6", regs[6], 32'h1);
        go(34); chk("sub_r1", regs[1], 32'h0);
        go(40);
        chk("r0_fwd_r7", regs[7], 32'h0);
        chk("addi_r8", regs[8], 32'h1);
        chk("final_r2", regs[2], 32'h100);
        chk("final_r3", regs[3], 32'h200);
        chk("final_r5", regs[5], 32'h100);
        chk("pc@40", dut.if_main.program_counter.out, 32'd156);

        reset = 1'b1;
        tick(1);
        chk("rst_pc", dut.if_main.program_counter.out, 32'h0);
        for (int r = 1; r < 32; r++) chk($sformatf("rst_r%0d", r), regs[r], 32'h0);
        chk("rst_keep_m3", dut.mem_main.data_memory.block[3], 32'h100);
        chk("rst_keep_m4", dut.mem_main.data_memory.block[4], 32'h200);

        reset = 1'b0;
        cyc = 0;
        tick(1); chk("rerun_pc@1", dut.if_main.program_counter.out, 32'h4);
        go(25);
        chk("rerun_r1", regs[1], 32'h7);
        chk("rerun_r3_pending", regs[3], 32'h0);
        reset = 1'b1;
        tick(1);
        chk("flush_r1", regs[1], 32'h0);
        chk("flush_pc", dut.if_main.program_counter.out, 32'h0);
        reset = 1'b0;
        cyc = 0;
        go(5);
        chk("flush_r3", regs[3], 32'h0);
        chk("flush_r2", regs[2], 32'h0);
        chk("flush_pc@5", dut.if_main.program_counter.out, 32'd20);
        chk("flush_keep_m3", dut.mem_main.data_memory.block[3], 32'h100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
